// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, MSB-first data, optional even parity, stop bit.
// Define SERIAL_PARITY_EN to insert the parity bit between the data LSB and the stop bit.
module serial_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    even_parity = ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic             serial_next;
  logic             busy_next;
  logic             done_next;
  logic             accept;
`ifdef SERIAL_PARITY_EN
  logic [WIDTH-1:0] par_word;
`endif

  // ready is the only output not registered, so an accept is possible on the first edge after reset release
  assign ready_out = (state == IDLE) && !rst;
  assign accept    = valid_in && ready_out;

  // Next-state, shift register and counter decode
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shreg_next = data_in;
          cnt_next   = '0;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        state_next = DATA;
      end
      DATA: begin
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
        cnt_next   = cnt + CW'(1);
        if (cnt == LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end else begin
          state_next = DATA;
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        state_next = STOP;
      end
`endif
      STOP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so they come straight out of flops
  always_comb begin
    serial_next = 1'b1;
    busy_next   = (state_next != IDLE);
    done_next   = (state_next == STOP);
    case (state_next)
      IDLE:   serial_next = 1'b1;
      START:  serial_next = 1'b0;
      DATA:   serial_next = shreg_next[WIDTH-1];
`ifdef SERIAL_PARITY_EN
      PARITY: serial_next = even_parity(par_word);
`endif
      STOP:   serial_next = 1'b1;
      default: serial_next = 1'b1;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      cnt        <= cnt_next;
      serial_out <= serial_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

`ifdef SERIAL_PARITY_EN
  // Parity is taken from an untouched copy of the accepted word, not the shifting register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_word <= '0;
    end else if (accept) begin
      par_word <= data_in;
    end else begin
      par_word <= par_word;
    end
  end
`endif

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: table vectors, corner sequences and randomized frames.
`timescale 1ns/1ps
module tb_serial_frame_tx;

  localparam int W = 8;
`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = W + 2 + PAR;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_out;
  logic         serial_out;
  logic         busy;
  logic         done;
  logic [1:0]   ds;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [10:0]  frame;   // frame[10] is the first bit on the line
    bit           hold;
    logic [W-1:0] junk;
  } vec_t;

  vec_t tbl[4];

  serial_frame_tx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .serial_out(serial_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // downstream falling-edge shift stage, two deep
  always @(negedge clk) ds <= {ds[0], serial_out};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: bit k of the line for word w
  function automatic logic model_bit(input logic [W-1:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k <= W) return w[W-k];
    if (PAR == 1 && k == W + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_idle_serial"}, serial_out, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_done"}, done, 1'b0);
    chk({tag, "_idle_ready"}, ready_out, 1'b1);
  endtask

  // Called just after a falling edge with the DUT idle; returns at the mandatory idle cycle
  task automatic run_frame(input string tag, input logic [W-1:0] word, input logic [10:0] exp,
                           input bit hold, input logic [W-1:0] junk);
    chk({tag, "_ready_before"}, ready_out, 1'b1);
    data_in  = word;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    data_in  = junk;
    valid_in = hold;
    for (int k = 0; k < FLEN; k++) begin
      tick();
      chk($sformatf("%s_serial_b%0d", tag, k), serial_out, exp[10-k]);
      chk($sformatf("%s_done_b%0d", tag, k), done, (k == FLEN - 1));
      chk($sformatf("%s_busy_b%0d", tag, k), busy, 1'b1);
      chk($sformatf("%s_ready_b%0d", tag, k), ready_out, 1'b0);
      if (k > 0) chk($sformatf("%s_stage_b%0d", tag, k), ds[1], exp[11-k]);
    end
    tick();
    check_idle(tag);
    chk({tag, "_stage_stop"}, ds[1], 1'b1);
  endtask

  initial begin
    logic [10:0] f;
    logic [W-1:0] w;
    int gap;
    bit h;

`ifdef SERIAL_PARITY_EN
    tbl[0] = '{data: 8'hA5, frame: 11'b01010010101, hold: 1'b0, junk: 8'h5A};
    tbl[1] = '{data: 8'h01, frame: 11'b00000000111, hold: 1'b0, junk: 8'hFE};
    tbl[2] = '{data: 8'h3C, frame: 11'b00011110001, hold: 1'b1, junk: 8'hFF};
    tbl[3] = '{data: 8'hFF, frame: 11'b01111111101, hold: 1'b0, junk: 8'h00};
`else
    tbl[0] = '{data: 8'hA5, frame: 11'b01010010110, hold: 1'b0, junk: 8'h5A};
    tbl[1] = '{data: 8'h01, frame: 11'b00000000110, hold: 1'b0, junk: 8'hFE};
    tbl[2] = '{data: 8'h3C, frame: 11'b00011110010, hold: 1'b1, junk: 8'hFF};
    tbl[3] = '{data: 8'hFF, frame: 11'b01111111110, hold: 1'b0, junk: 8'h00};
`endif

    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    #2;
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", ready_out, 1'b0);
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      check_idle("post_rst");
    end

    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].frame, tbl[i].hold, tbl[i].junk);
    end
    valid_in = 1'b0;
    tick();
    check_idle("tbl_end");

    // asynchronous reset while the fourth data bit of 8'hF0 is on the line
    data_in  = 8'hF0;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    data_in  = 8'h0F;
    repeat (5) tick();
    chk("mid_bit3", serial_out, 1'b1);
    chk("mid_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_serial", serial_out, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ready", ready_out, 1'b0);
    tick();
    chk("mid_hold_busy", busy, 1'b0);
    chk("mid_hold_done", done, 1'b0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      check_idle("mid_after");
    end
    run_frame("mid_new", tbl[0].data, tbl[0].frame, 1'b0, 8'h33);

    // randomized frames against the reference model
    for (int r = 0; r < 30; r++) begin
      w = W'($urandom);
      h = 1'($urandom_range(0, 1));
      f = '0;
      for (int k = 0; k < FLEN; k++) f[10-k] = model_bit(w, k);
      run_frame($sformatf("rnd%0d", r), w, f, h, W'($urandom));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        valid_in = 1'b0;
        repeat (gap) begin
          tick();
          check_idle($sformatf("rnd%0d_gap", r));
        end
      end else begin
        valid_in = valid_in;
      end
    end

    valid_in = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial frame transmitter that produces the serial bit stream consumed by the workshop's negedge-clocked shift register stage. It accepts a WIDTH-bit word through a valid/ready handshake and emits one framed bit per clock: a start bit, the data MSB-first, optionally a parity bit, and a stop bit. All outputs update on the rising edge of `clk`, so the downstream falling-edge stage always samples a value that has been stable for half a cycle.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range 2..32.
- `clk`  input  1: single clock; all state updates on posedge.
- `rst`  input  1: asynchronous, active-high reset.
- `data_in`  input  WIDTH: parallel word to transmit; sampled only on the accepting edge.
- `valid_in`  input  1: upstream has a word on `data_in`.
- `ready_out`  output  1: block can accept a word (high only in IDLE, forced low while `rst` is high).
- `serial_out`  output  1: serial bit stream to the downstream shift register; idle level 1.
- `busy`  output  1: a frame is in progress (any state other than IDLE).
- `done`  output  1: high for exactly the one cycle in which the stop bit is on `serial_out`.

## Operation
- Registered FSM with states IDLE, START, DATA, PARITY (present only with `SERIAL_PARITY_EN`), and STOP.
- IDLE: `serial_out`=1, `busy`=0, `done`=0, `ready_out`=1.
  - On a posedge with `valid_in`=1 and `ready_out`=1, `data_in` is copied into an internal WIDTH-bit shift register, the bit counter is cleared, and the FSM goes to START.
- START: `serial_out`=0 for one cycle, then DATA.
- DATA:
  - `serial_out` = shift register MSB; the register shifts left by one per cycle.
  - The counter (width $clog2(WIDTH)) increments per cycle.
  - After the bit with counter = WIDTH-1, the FSM goes to PARITY if `SERIAL_PARITY_EN` is defined, otherwise to STOP.
- PARITY: `serial_out` = even-parity bit (XOR of the latched word) for one cycle, then STOP.
  - The parity is computed from a copy captured at acceptance, not from the shifting register.
- STOP: `serial_out`=1 and `done`=1 for one cycle, then IDLE.
- `valid_in` while `busy`=1 is ignored. There is no queueing: upstream must hold `valid_in` and `data_in` until it sees `ready_out`=1 on a posedge.
- Changes on `data_in` after the accepting edge have no effect on the frame in flight.
- All outputs are decoded from registered state, so there is no combinational path from `valid_in` or `data_in` to any output.
- Reset (async, any time, including mid-frame): state becomes IDLE, shift register and counter become 0, `serial_out`=1, `busy`=0, `done`=0, `ready_out`=0 while `rst` is high.
  - The frame in flight is abandoned and never resumed.
  - First possible accept is the first posedge after `rst` deasserts.

## Timing
- Let E0 be the accepting posedge.
- After E0: start bit (0). After E1..EWIDTH: data bits MSB to LSB.
- After EWIDTH+1: stop bit (no parity), or parity bit then stop bit after EWIDTH+2.
- Frame length: WIDTH+2 cycles (WIDTH+3 with parity).
- After the stop-bit cycle the FSM spends at least one cycle in IDLE before the next accept.
  - Back-to-back words therefore have a period of WIDTH+3 cycles (WIDTH+4 with parity).
- `busy` rises after E0 and falls on the edge that ends STOP. `done` coincides with STOP.
- `ready_out` falls after E0 and rises on the same edge that `busy` falls.

## Configuration
- `SERIAL_PARITY_EN`
  - Defined: the PARITY state exists and one even-parity bit is inserted between the data LSB and the stop bit.
  - Undefined: the PARITY state and parity logic are not compiled; the frame goes directly from DATA to STOP.
  - Port list and handshake are identical in both builds.

## Test plan
- Reset: assert `rst` asynchronously, away from any clock edge. Required immediately: `serial_out`=1, `busy`=0, `done`=0, `ready_out`=0. After release: `ready_out`=1 and `serial_out` stays 1 until a word is accepted.
- Single frame, WIDTH=8, no parity: `data_in`=8'hA5 with `valid_in` pulsed for one accepting edge. Required: `serial_out` sequence 0,1,0,1,0,0,1,0,1,1 over 10 cycles, with `done`=1 only on the final 1.
- Parity build: 8'hA5 gives parity bit 0 after the LSB, then stop 1. 8'h01 gives parity bit 1. Frame length is 11 cycles.
- Ignored request: hold `valid_in`=1 and set `data_in`=8'hFF during an 8'h3C frame. Required:
  - The 8'h3C bits are unaffected.
  - 8'hFF is accepted on the first edge after the IDLE cycle following STOP.
  - Frame period is 11 cycles.
- Reset mid-frame: assert `rst` during DATA bit 3 of 8'hF0. Required: `serial_out`=1 and `busy`=0 immediately, with no stop or `done` pulse. A new word sent after release transmits correctly.
- Downstream integration: connect `serial_out` to the negedge shift stage's input. The stage's output must reproduce the transmitted bit sequence delayed by its pipeline depth, with no setup violations at half-cycle sampling.
